alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits; only 32 is supported.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port alu_op  input  4  operation code from the ALU-op decoder.
REQ-007 SHALL have port a  input  32  operand A (rs1 or PC).
REQ-008 SHALL have port b  input  32  operand B (rs2 or immediate).
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-011 SHALL have port result  output  32  registered result.
REQ-012 SHALL have port zero  output  1  registered flag, 1 when result equals 0 (branch compare).

Function
REQ-013 SHALL decode alu_op as: 0000 add; 1000 sub; 0001 sll; 0010 slt (signed, result 1/0); 0011 sltu; 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and; all other codes treated as add.
REQ-014 SHALL perform add/sub modulo 2^32, ignoring carry and overflow.
REQ-015 SHALL use only b[4:0] as the shift amount; b[31:5] ignored for shifts.
REQ-016 SHALL accept a request on a rising edge where in_valid and in_ready are both 1; operands and alu_op are captured at that edge and may change afterwards.
REQ-017 SHALL drive in_ready = 1 only in state IDLE and only when out_valid is 0 or out_ready is 1 in the same cycle.
REQ-018 SHALL implement states IDLE and SHIFT: IDLE -> SHIFT on accepting a shift op with nonzero shift amount; SHIFT -> IDLE on the edge the remaining count reaches 0; all other accepts stay in IDLE.
REQ-019 SHALL, for non-shift ops and shifts by 0, raise out_valid on the edge after acceptance (latency 1).
REQ-020 SHALL, in SHIFT, shift the working register by one bit per cycle (sra replicates bit 31), raising out_valid after shamt+1 cycles from acceptance (e.g. shamt 31 -> 32 cycles).
REQ-021 SHALL hold result, zero and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid on the edge where out_valid and out_ready are 1, unless a new result is loaded on the same edge, in which case out_valid stays 1 with the new result.
REQ-023 SHALL ignore in_valid while in SHIFT; no request is lost because in_ready is 0 there.

Reset
REQ-024 SHALL on rst_n=0 immediately force state IDLE, out_valid 0, result 0, zero 1, shift counter 0; in_ready reads 1 after reset release.
REQ-025 SHALL abort any in-progress shift on reset with no result delivered.

Configuration
REQ-026 SHALL, with macro ALU_FAST_SHIFT_EN defined, implement all shifts combinationally with latency 1, never entering SHIFT.
REQ-027 SHALL, without ALU_FAST_SHIFT_EN, use the serial shifter of REQ-018/REQ-020; results are bit-identical in both builds.

Verification
REQ-028 SHALL verify: op 0000, a=0xFFFFFFFF, b=1 -> next cycle out_valid=1, result=0, zero=1.
REQ-029 SHALL verify: op 1101, a=0x80000000, b=0x24 (shamt 4) -> result 0xF8000000 after 5 cycles (1 cycle with ALU_FAST_SHIFT_EN), in_ready=0 meanwhile.
REQ-030 SHALL verify: op 0010, a=0xFFFFFFFF, b=1 -> result 1; op 0011 same operands -> result 0, zero=1.
REQ-031 SHALL verify back-to-back: out_ready held 0 for 3 cycles after result 5 -> result/out_valid stable, in_ready=0; out_ready=1 with new in_valid (add 2+3) -> same-edge drain and load, out_valid stays 1, result 5 then 5.
REQ-032 SHALL verify: rst_n pulsed low mid-way through sll by 20 -> out_valid=0, result=0 immediately, in_ready=1 after release, next add 1+1 returns 2.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: single-issue integer ALU with valid/ready handshakes and a
// registered result. Shifts use a one-bit-per-cycle serial shifter unless
// ALU_FAST_SHIFT_EN is defined, in which case they complete in one cycle
// like every other operation. Results are identical in both builds.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request when the output slot is free or draining
// SHIFT | serial shift in progress, one bit per cycle, in_ready low
module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q;
    logic [1:0]      shtype_q;
    logic [XLEN-1:0] work_q;
    logic [XLEN-1:0] work_step;
    logic [XLEN-1:0] comb_res;
    logic [4:0]      shamt;
    logic [1:0]      shtype_in;
    logic            is_shift;
    logic            accept;
    logic            start_serial;
    logic            load_direct;
    logic            shift_done;

    assign shamt    = b[4:0];
    assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
    assign accept   = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign start_serial = 1'b0;
`else
    assign start_serial = accept && is_shift && (shamt != 5'd0);
`endif

    assign load_direct = accept && !start_serial;
    assign shift_done  = (state_q == SHIFT) && (cnt_q == 5'd1);

    // Single-cycle result for every op that completes at the accept edge.
    // Without the fast shifter only shift-by-zero lands here, so a passes through.
    always_comb begin
        comb_res = a + b;
        case (alu_op)
            OP_SUB:  comb_res = a - b;
            OP_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: comb_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  comb_res = a ^ b;
            OP_OR:   comb_res = a | b;
            OP_AND:  comb_res = a & b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  comb_res = a << shamt;
            OP_SRL:  comb_res = a >> shamt;
            OP_SRA:  comb_res = $unsigned($signed(a) >>> shamt);
`else
            OP_SLL,
            OP_SRL,
            OP_SRA:  comb_res = a;
`endif
            default: comb_res = a + b;
        endcase
    end

    // Shift kind captured at accept, and the one-bit step of the working register.
    always_comb begin
        shtype_in = SH_SLL;
        if (alu_op == OP_SRL) shtype_in = SH_SRL;
        if (alu_op == OP_SRA) shtype_in = SH_SRA;
        case (shtype_q)
            SH_SLL:  work_step = {work_q[XLEN-2:0], 1'b0};
            SH_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
            default: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and the request-side handshake.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !out_valid || out_ready;
                if (start_serial) state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == 5'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial shifter working register and remaining-count down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            cnt_q    <= 5'd0;
            shtype_q <= SH_SLL;
        end else if (start_serial) begin
            work_q   <= a;
            cnt_q    <= shamt;
            shtype_q <= shtype_in;
        end else if (state_q == SHIFT) begin
            work_q   <= work_step;
            cnt_q    <= cnt_q - 5'd1;
        end
    end

    // Output slot: load a new result, otherwise drain on handshake, otherwise hold.
    // A serial shift only starts when the slot is free or draining, so the
    // slot is always empty by the time the shift completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else if (load_direct) begin
            out_valid <= 1'b1;
            result    <= comb_res;
            zero      <= (comb_res == '0);
        end else if (shift_done) begin
            out_valid <= 1'b1;
            result    <= work_step;
            zero      <= (work_step == '0);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
